ram_dma_copy: RTL and testbench

- Initiator-side engine that drives both ports of a dual-port synchronous RAM (1-cycle read latency, read-first).
- Copies a block of len words from a source region to a destination region at one word per cycle.
- Port 0 is used for reads only; port 1 is used for writes only.
- Sits between a control master (CPU or sequencer: start/busy/done) and the RAM.

---
 rtl/ram_dma_pkg.sv | 14 +
 rtl/ram_dma_copy.sv | 147 ++++++++++++++
 tb/tb_ram_dma_copy.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared state encoding and RAM timing constants for ram_dma_copy
package ram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Synchronous RAM read latency; the write pipeline trails reads by this many cycles.
    localparam int RD_LAT        = 1;
    localparam int WR_PIPE_DEPTH = RD_LAT;

endpackage

// File: rtl/ram_dma_copy.sv
// rtl/ram_dma_copy.sv - dual-port RAM block copy engine; optional fill mode under RAM_DMA_COPY_FILL_EN
module ram_dma_copy
    import ram_dma_pkg::*;
#(
    parameter int dat_width = 32,
    parameter int adr_width = 32,
    parameter int len_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [adr_width-1:0] src_adr_i,
    input  logic [adr_width-1:0] dst_adr_i,
    input  logic [len_width-1:0] len_i,
`ifdef RAM_DMA_COPY_FILL_EN
    input  logic                 fill_i,
    input  logic [dat_width-1:0] fill_dat_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic [adr_width-1:0] adr0_o,
    output logic                 we0_o,
    output logic [dat_width-1:0] dat0_o,
    input  logic [dat_width-1:0] dat0_i,
    output logic [adr_width-1:0] adr1_o,
    output logic                 we1_o,
    output logic [dat_width-1:0] dat1_o
);

    localparam int DRAIN_W = (WR_PIPE_DEPTH > 1) ? $clog2(WR_PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WR_PIPE_DEPTH - 1);

    state_t               state;
    logic [len_width-1:0] rem;
    logic [adr_width-1:0] wr_adr;
    logic [DRAIN_W-1:0]   drain_cnt;

    assign we0_o  = 1'b0;
    assign dat0_o = '0;

`ifdef RAM_DMA_COPY_FILL_EN
    logic                 fill_q;
    logic [dat_width-1:0] fill_dat_q;

    assign dat1_o = fill_q ? fill_dat_q : dat0_i;
`else
    // Write data is the word read one cycle earlier, passed straight through.
    assign dat1_o = dat0_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            wr_adr    <= '0;
            drain_cnt <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            we1_o     <= 1'b0;
            adr0_o    <= '0;
            adr1_o    <= '0;
`ifdef RAM_DMA_COPY_FILL_EN
            fill_q     <= 1'b0;
            fill_dat_q <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    we1_o <= 1'b0;
                    // The done cycle is not an accepting cycle.
                    if (start_i && !done_o) begin
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy_o    <= 1'b1;
                            rem       <= len_i - 1'b1;
                            drain_cnt <= '0;
`ifdef RAM_DMA_COPY_FILL_EN
                            fill_q     <= fill_i;
                            fill_dat_q <= fill_dat_i;
                            if (fill_i) begin
                                we1_o  <= 1'b1;
                                adr1_o <= dst_adr_i;
                                wr_adr <= dst_adr_i + 1'b1;
                            end else begin
                                adr0_o <= src_adr_i;
                                wr_adr <= dst_adr_i;
                            end
`else
                            adr0_o <= src_adr_i;
                            wr_adr <= dst_adr_i;
`endif
                        end
                    end
                end

                RUN: begin
`ifdef RAM_DMA_COPY_FILL_EN
                    if (fill_q) begin
                        if (rem == '0) begin
                            state  <= IDLE;
                            we1_o  <= 1'b0;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            we1_o  <= 1'b1;
                            adr1_o <= wr_adr;
                            wr_adr <= wr_adr + 1'b1;
                            rem    <= rem - 1'b1;
                        end
                    end else
`endif
                    begin
                        we1_o  <= 1'b1;
                        adr1_o <= wr_adr;
                        wr_adr <= wr_adr + 1'b1;
                        if (rem == '0) begin
                            state <= DRAIN;
                        end else begin
                            adr0_o <= adr0_o + 1'b1;
                            rem    <= rem - 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= IDLE;
                        we1_o  <= 1'b0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        we1_o     <= 1'b1;
                        adr1_o    <= wr_adr;
                        wr_adr    <= wr_adr + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma_copy.sv
// tb/tb_ram_dma_copy.sv - self-checking bench for ram_dma_copy with a dual-port RAM responder
module tb_ram_dma_copy;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] src_adr_i;
    logic [AW-1:0] dst_adr_i;
    logic [LW-1:0] len_i;
    logic          fill_i;
    logic [DW-1:0] fill_dat_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] adr0_o;
    logic          we0_o;
    logic [DW-1:0] dat0_o;
    logic [DW-1:0] dat0_i;
    logic [AW-1:0] adr1_o;
    logic          we1_o;
    logic [DW-1:0] dat1_o;

    always #5 clk = ~clk;

    ram_dma_copy #(.dat_width(DW), .adr_width(AW), .len_width(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .src_adr_i (src_adr_i),
        .dst_adr_i (dst_adr_i),
        .len_i     (len_i),
`ifdef RAM_DMA_COPY_FILL_EN
        .fill_i    (fill_i),
        .fill_dat_i(fill_dat_i),
`endif
        .busy_o    (busy_o),
        .done_o    (done_o),
        .adr0_o    (adr0_o),
        .we0_o     (we0_o),
        .dat0_o    (dat0_o),
        .dat0_i    (dat0_i),
        .adr1_o    (adr1_o),
        .we1_o     (we1_o),
        .dat1_o    (dat1_o)
    );

    // Unwritten RAM locations read back as a fixed address hash.
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA0A0_0000;
    endfunction

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        dat0_i <= rd_mem(adr0_o);
        if (we1_o) mem[adr1_o] = dat1_o;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            rel;
    } wr_t;

    wr_t sb[$];
    int  cyc      = 0;
    int  t0       = 0;
    int  busy_cnt = 0;
    int  done_cnt = 0;
    int  done_rel = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we0_o) check("we0_asserted", 64'(we0_o), 64'd0);
        if (busy_o) busy_cnt++;
        if (done_o) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
        if (we1_o) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_adr", 64'(adr1_o), 64'(e.adr));
                check("wr_dat", 64'(dat1_o), 64'(e.dat));
                check("wr_cyc", 64'(cyc - t0), 64'(e.rel));
            end
        end
    end

    task automatic run(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n,
                       input bit fill, input logic [DW-1:0] fdat, input bit repulse,
                       input int rst_at);
        int nwr;
        int exp_busy;
        wr_t e;
        busy_cnt = 0;
        done_cnt = 0;
        done_rel = -1;
        nwr = (rst_at > 0) ? rst_at - 1 : n;
        for (int k = 0; k < nwr; k++) begin
            e.adr = dst + AW'(k);
            e.dat = fill ? fdat : pat(src + AW'(k));
            e.rel = fill ? k + 1 : k + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        src_adr_i  = src;
        dst_adr_i  = dst;
        len_i      = LW'(n);
        fill_i     = fill;
        fill_dat_i = fdat;
        start_i    = 1'b1;
        t0         = cyc;
        for (int r = 1; r <= n + 6; r++) begin
            @(negedge clk);
            start_i = repulse && (r == 2 || r == n + 2);
            rst     = (rst_at == r);
            if (r == 2) begin
                src_adr_i  = ~src;
                dst_adr_i  = ~dst;
                len_i      = LW'(n + 3);
                fill_i     = ~fill;
                fill_dat_i = ~fdat;
            end
            if (rst_at > 0 && r == rst_at + 1) begin
                check("rst_busy", 64'(busy_o), 64'd0);
                check("rst_we1", 64'(we1_o), 64'd0);
                check("rst_adr1", 64'(adr1_o), 64'd0);
            end
        end
        start_i = 1'b0;
        rst     = 1'b0;
        exp_busy = (rst_at > 0) ? rst_at : (n == 0) ? 0 : fill ? n : n + 1;
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check("done_count", 64'(done_cnt), (rst_at > 0) ? 64'd0 : 64'd1);
        if (rst_at == 0)
            check("done_cyc", 64'(done_rel), (n == 0) ? 64'd1 : fill ? 64'(n + 1) : 64'(n + 2));
        check("missing_wr", 64'(sb.size()), 64'd0);
        sb.delete();
        for (int k = 0; k < n; k++) begin
            check("ram_dst", 64'(rd_mem(dst + AW'(k))),
                  (k < nwr) ? (fill ? 64'(fdat) : 64'(pat(src + AW'(k)))) : 64'(pat(dst + AW'(k))));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        src_adr_i  = '0;
        dst_adr_i  = '0;
        len_i      = '0;
        fill_i     = 1'b0;
        fill_dat_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_we1", 64'(we1_o), 64'd0);
        check("reset_adr0", 64'(adr0_o), 64'd0);
        check("reset_adr1", 64'(adr1_o), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(32'h10, 32'h40, 4, 1'b0, '0, 1'b0, 0);
        run(32'h10, 32'h50, 0, 1'b0, '0, 1'b0, 0);
        run(32'h10, 32'h60, 4, 1'b0, '0, 1'b1, 0);
        run(32'h30, 32'h80, 8, 1'b0, '0, 1'b0, 3);
        run(32'hFFFF_FFFE, 32'h100, 4, 1'b0, '0, 1'b0, 0);
        run(32'h200, 32'h300, 1, 1'b0, '0, 1'b0, 0);
`ifdef RAM_DMA_COPY_FILL_EN
        run(32'h10, 32'h20, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        run(32'h10, 32'h28, 1, 1'b1, 32'h1234_5678, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
